// File: rtl/tx_scheduler_pkg.sv
// Shared types for the UART transmit scheduler: FSM states and the shadowed line configuration.
package tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_sched_state_t;

    typedef struct packed {
        logic [15:0] acc_incr;
        logic        ds;
        logic [1:0]  p;
        logic        s;
    } line_cfg_t;

    localparam line_cfg_t LINE_CFG_RESET = '0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: read data is the head, combinational; push/pop take effect on the edge.
// A push while full is accepted only if a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tx_scheduler.sv
// Buffers register-written bytes and hands them to tx_frontend one frame at a time with a frozen config.
// Push-to-start is 2 cycles; pushes while full (and no pop) are dropped and flagged in overflow_o.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic [15:0]              cr_acc_incr_i,
    input  logic                     cr_ds_i,
    input  logic [1:0]               cr_p_i,
    input  logic                     cr_s_i,
    output logic [15:0]              fe_cr_acc_incr_o,
    output logic                     fe_cr_ds_o,
    output logic [1:0]               fe_cr_p_o,
    output logic                     fe_cr_s_o,
    output logic                     fe_transmit_o,
    output logic [7:0]               fe_dr_o,
    input  logic                     fe_done_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     clear_overflow_i,
    output logic                     busy_o,
    output logic                     irq_o
);
    tx_sched_state_t state_q;
    tx_sched_state_t state_d;
    line_cfg_t       cfg_q;
    logic [7:0]      dr_q;
    logic            irq_q;
    logic            overflow_q;
    logic            start;
    logic            done_accept;
    logic            drop;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_i),
        .wdata (push_data_i),
        .pop   (start),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign start       = (state_q == IDLE) && enable_i && !fifo_empty;
    assign done_accept = (state_q == WAIT) && fe_done_i;
    assign drop        = push_i && fifo_full && !start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (fe_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cfg_q      <= LINE_CFG_RESET;
            dr_q       <= 8'h00;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dr_q  <= fifo_head;
                cfg_q <= '{acc_incr: cr_acc_incr_i, ds: cr_ds_i, p: cr_p_i, s: cr_s_i};
            end
            // No pop can happen in WAIT, so "empty after the edge" means empty now and no push.
            irq_q <= done_accept && fifo_empty && !push_i;
            if (drop)
                overflow_q <= 1'b1;
            else if (clear_overflow_i)
                overflow_q <= 1'b0;
        end
    end

    assign fe_transmit_o    = (state_q == SEND);
    assign busy_o           = (state_q != IDLE);
    assign fe_dr_o          = dr_q;
    assign fe_cr_acc_incr_o = cfg_q.acc_incr;
    assign fe_cr_ds_o       = cfg_q.ds;
    assign fe_cr_p_o        = cfg_q.p;
    assign fe_cr_s_o        = cfg_q.s;
    assign irq_o            = irq_q;
    assign overflow_o       = overflow_q;
    assign full_o           = fifo_full;
    assign empty_o          = fifo_empty;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: hand-computed cycle-exact expectations, sampled 1 time unit after each edge.
module tb_tx_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        enable_i = 1'b1;
    logic        push_i = 1'b0;
    logic [7:0]  push_data_i = 8'h00;
    logic [15:0] cr_acc_incr_i = 16'h0000;
    logic        cr_ds_i = 1'b0;
    logic [1:0]  cr_p_i = 2'd0;
    logic        cr_s_i = 1'b0;
    logic [15:0] fe_cr_acc_incr_o;
    logic        fe_cr_ds_o;
    logic [1:0]  fe_cr_p_o;
    logic        fe_cr_s_o;
    logic        fe_transmit_o;
    logic [7:0]  fe_dr_o;
    logic        fe_done_i = 1'b0;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic        clear_overflow_i = 1'b0;
    logic        busy_o;
    logic        irq_o;

    int checks = 0;
    int passes = 0;
    logic seen;
    logic [7:0] v;

    tx_scheduler #(.DEPTH(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .enable_i         (enable_i),
        .push_i           (push_i),
        .push_data_i      (push_data_i),
        .cr_acc_incr_i    (cr_acc_incr_i),
        .cr_ds_i          (cr_ds_i),
        .cr_p_i           (cr_p_i),
        .cr_s_i           (cr_s_i),
        .fe_cr_acc_incr_o (fe_cr_acc_incr_o),
        .fe_cr_ds_o       (fe_cr_ds_o),
        .fe_cr_p_o        (fe_cr_p_o),
        .fe_cr_s_o        (fe_cr_s_o),
        .fe_transmit_o    (fe_transmit_o),
        .fe_dr_o          (fe_dr_o),
        .fe_done_i        (fe_done_i),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .level_o          (level_o),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i),
        .busy_o           (busy_o),
        .irq_o            (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_flags"}, {26'd0, empty_o, full_o, overflow_o, fe_transmit_o, irq_o, busy_o},
            32'b100000);
        chk({tag, "_dr"}, 32'(fe_dr_o), 32'h00);
        chk({tag, "_cfg"}, 32'({fe_cr_acc_incr_o, fe_cr_ds_o, fe_cr_p_o, fe_cr_s_o}), 32'd0);
    endtask

    // Called in a start cycle S: answers with fe_done_i in S+5, checks the IDLE cycle after it,
    // and returns in S+7 where the next start (if any) is due.
    task automatic answer_frame(input string tag, input logic exp_irq);
        tick();
        push_i = 1'b0;
        repeat (4) tick();
        fe_done_i = 1'b1;
        tick();
        fe_done_i = 1'b0;
        chk({tag, "_irq"}, 32'(irq_o), 32'(exp_irq));
        chk({tag, "_idle"}, {30'd0, busy_o, fe_transmit_o}, 32'd0);
        tick();
    endtask

    initial begin
        // Reset
        #2 rst_i = 1'b1;
        #2;
        chk_reset_vals("reset");
        tick();
        tick();
        rst_i = 1'b0;

        // Single byte: start 2 cycles after push, done 20 cycles after start
        push_data_i = 8'h55;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
        chk("t1_empty_fall", {30'd0, empty_o, fe_transmit_o}, 32'b00);
        tick();
        chk("t1_start", {22'd0, fe_transmit_o, busy_o, fe_dr_o}, {22'd0, 2'b11, 8'h55});
        repeat (20) tick();
        fe_done_i = 1'b1;
        tick();
        fe_done_i = 1'b0;
        chk("t1_irq", {30'd0, irq_o, busy_o}, 32'b10);
        tick();
        chk("t1_irq_pulse", 32'(irq_o), 32'd0);

        // Three back-to-back bytes
        push_data_i = 8'h01;
        push_i = 1'b1;
        tick();
        push_data_i = 8'h02;
        tick();
        push_data_i = 8'h03;
        chk("t2_start1", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h01});
        answer_frame("t2_f1", 1'b0);
        chk("t2_start2", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h02});
        answer_frame("t2_f2", 1'b0);
        chk("t2_start3", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h03});
        answer_frame("t2_f3", 1'b1);
        chk("t2_drained", {30'd0, fe_transmit_o, empty_o}, 32'b01);

        // Fill while disabled, overflow on the 9th push, then drain with wrapped pointers
        enable_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_data_i = 8'hA0 + 8'(i);
            push_i = 1'b1;
            tick();
        end
        chk("t3_full", {27'd0, full_o, level_o}, {27'd0, 1'b1, 4'd8});
        chk("t3_no_ovf_yet", 32'(overflow_o), 32'd0);
        push_data_i = 8'hEE;
        tick();
        push_i = 1'b0;
        chk("t3_ovf", {26'd0, overflow_o, full_o, level_o}, {26'd0, 2'b11, 4'd8});
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        chk("t3_ovf_clear", 32'(overflow_o), 32'd0);
        chk("t3_disabled", 32'(busy_o), 32'd0);
        enable_i = 1'b1;
        tick();
        chk("t3_start0", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'hA0});
        for (int i = 1; i < 8; i++) begin
            answer_frame("t3_f", 1'b0);
            v = 8'hA0 + 8'(i);
            chk("t3_start", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, v});
        end
        answer_frame("t3_last", 1'b1);
        seen = 1'b0;
        repeat (10) begin
            if (fe_transmit_o) seen = 1'b1;
            tick();
        end
        chk("t3_ninth_dropped", {30'd0, seen, empty_o}, 32'b01);

        // Shadow configuration frozen across a frame
        cr_acc_incr_i = 16'h1000;
        cr_ds_i = 1'b1;
        cr_p_i = 2'd0;
        cr_s_i = 1'b0;
        push_data_i = 8'h11;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
        tick();
        chk("t4_cfg_a", 32'({fe_cr_acc_incr_o, fe_cr_ds_o, fe_cr_p_o, fe_cr_s_o}),
            32'({16'h1000, 1'b1, 2'd0, 1'b0}));
        tick();
        cr_acc_incr_i = 16'h2000;
        cr_p_i = 2'd2;
        cr_s_i = 1'b1;
        push_data_i = 8'h22;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
        chk("t4_cfg_wait", 32'({fe_cr_acc_incr_o, fe_cr_ds_o, fe_cr_p_o, fe_cr_s_o}),
            32'({16'h1000, 1'b1, 2'd0, 1'b0}));
        tick();
        fe_done_i = 1'b1;
        tick();
        fe_done_i = 1'b0;
        chk("t4_cfg_idle", 32'({fe_cr_acc_incr_o, fe_cr_ds_o, fe_cr_p_o, fe_cr_s_o}),
            32'({16'h1000, 1'b1, 2'd0, 1'b0}));
        chk("t4_no_irq", 32'(irq_o), 32'd0);
        tick();
        chk("t4_start2", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h22});
        chk("t4_cfg_b", 32'({fe_cr_acc_incr_o, fe_cr_ds_o, fe_cr_p_o, fe_cr_s_o}),
            32'({16'h2000, 1'b1, 2'd2, 1'b1}));
        answer_frame("t4_end", 1'b1);

        // Asynchronous reset in WAIT with 3 bytes queued
        push_data_i = 8'h31;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
        tick();
        chk("t5_start", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h31});
        tick();
        push_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data_i = 8'h32 + 8'(i);
            tick();
        end
        push_i = 1'b0;
        chk("t5_queued", {27'd0, busy_o, level_o}, {27'd0, 1'b1, 4'd3});
        #2 rst_i = 1'b1;
        #1;
        chk_reset_vals("t5_rst");
        tick();
        tick();
        rst_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            if (fe_transmit_o) seen = 1'b1;
            tick();
        end
        chk("t5_quiet", {29'd0, seen, busy_o, empty_o}, 32'b001);

        // Push coinciding with fe_done_i suppresses irq and starts 2 cycles later
        push_data_i = 8'h41;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
        tick();
        chk("t6_start", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h41});
        repeat (3) tick();
        fe_done_i = 1'b1;
        push_data_i = 8'h77;
        push_i = 1'b1;
        tick();
        fe_done_i = 1'b0;
        push_i = 1'b0;
        chk("t6_suppressed", {29'd0, irq_o, busy_o, empty_o}, 32'b000);
        tick();
        chk("t6_start2", {23'd0, fe_transmit_o, fe_dr_o}, {23'd0, 1'b1, 8'h77});
        answer_frame("t6_end", 1'b1);

        // fe_done_i outside WAIT is ignored
        fe_done_i = 1'b1;
        tick();
        fe_done_i = 1'b0;
        tick();
        chk("t6_stray_done", {30'd0, irq_o, busy_o}, 32'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Sequences the UART transmit path: buffers bytes written by the register interface in a small FIFO and feeds them one at a time to `tx_frontend` through its `transmit_i`/`dr_i`/`done_o` handshake. It sits between the Wishbone register block and `tx_frontend`. It holds a per-frame shadow copy of the line configuration, so register writes never alter a frame in flight. It also reports FIFO status and the interrupt event.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; asynchronous and active-high.
- `enable_i` in 1: when low, no new frame starts; a frame in flight completes.
- `push_i` in 1: write strobe; one byte per cycle.
- `push_data_i` in 8: byte to enqueue.
- `cr_acc_incr_i` in 16, `cr_ds_i` in 1, `cr_p_i` in 2, `cr_s_i` in 1: live register configuration.
- `fe_cr_acc_incr_o` out 16, `fe_cr_ds_o` out 1, `fe_cr_p_o` out 2, `fe_cr_s_o` out 1: shadowed configuration to `tx_frontend`.
- `fe_transmit_o` out 1: one-cycle start pulse to `tx_frontend`.
- `fe_dr_o` out 8: byte to `tx_frontend`; valid while `fe_transmit_o` is high, then held.
- `fe_done_i` in 1: one-cycle end-of-frame pulse from `tx_frontend`.
- `full_o` out 1, `empty_o` out 1, `level_o` out clog2(DEPTH)+1: FIFO status.
- `overflow_o` out 1: sticky; set when a push is dropped.
- `clear_overflow_i` in 1: clears `overflow_o`.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `irq_o` out 1: one-cycle pulse when a frame finishes and the FIFO is empty.

## Operation
- States: IDLE, SEND, WAIT.
  - IDLE → SEND when `enable_i` is high and the FIFO is non-empty. That clock edge pops the head into `fe_dr_o` and latches all four `cr_*_i` into the `fe_cr_*_o` registers.
  - SEND → WAIT unconditionally; `fe_transmit_o` = (state == SEND).
  - WAIT → IDLE on `fe_done_i`. `fe_done_i` outside WAIT is ignored.
- The shadow configuration changes only on the IDLE→SEND edge.
- Push accounting:
  - A push while full is dropped and sets `overflow_o`.
  - A push while full in the same cycle as a pop is accepted; level is unchanged.
  - Push and pop in the same cycle on a non-empty FIFO: level is unchanged.
  - Pop on an empty FIFO cannot occur.
- `overflow_o`: set has priority over `clear_overflow_i` in the same cycle.
- `irq_o` fires on the WAIT→IDLE edge when the FIFO will be empty after that edge, counting a push in that same cycle. A push arriving in the `fe_done_i` cycle suppresses `irq_o`.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `level_o` ranges 0..DEPTH. `full_o` = (level == DEPTH); `empty_o` = (level == 0).

## Timing
- Reset, asserted at any time including mid-frame, immediately forces:
  - state IDLE; FIFO empty; `level_o` 0; `empty_o` 1; `full_o` 0; `overflow_o` 0;
  - `fe_transmit_o` 0; `irq_o` 0; `busy_o` 0; `fe_dr_o` 0x00;
  - `fe_cr_acc_incr_o` 0; `fe_cr_ds_o` 0; `fe_cr_p_o` 0; `fe_cr_s_o` 0.
- Push in cycle N with FIFO empty and state IDLE: `empty_o` falls in N+1, `fe_transmit_o` is high in N+2, `busy_o` is high from N+2.
- Back-to-back frames: `fe_done_i` in cycle M puts the state in IDLE in M+1 and gives the next `fe_transmit_o` in M+2. This is a guaranteed 1-cycle minimum gap.
- Every output is registered except the status outputs, which are decoded combinationally from registered state and pointers.

## Structure
- `tx_scheduler_pkg`: state enum `tx_sched_state_t` {IDLE, SEND, WAIT}.
- The verilator config exposes `state_q` publicly.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/level). The scheduler FSM, shadow registers, overflow flag and irq live in `tx_scheduler`.

## Test plan
- Reset released, push 0x55 → `fe_transmit_o` high exactly 2 cycles after the push with `fe_dr_o`=0x55. `fe_done_i` pulsed 20 cycles later → `irq_o` pulses on the next edge, `busy_o` drops.
- Push 0x01, 0x02, 0x03 back-to-back and answer each start with `fe_done_i` 5 cycles later → starts carry 0x01, 0x02, 0x03 in order, each exactly 2 cycles after the previous `fe_done_i`; single `irq_o` after the third.
- Fill with DEPTH=8 bytes while `enable_i`=0, push a 9th → `full_o`=1, `level_o`=8, `overflow_o`=1, and 9th byte never transmitted. Pulse `clear_overflow_i` → `overflow_o`=0.
- Change `cr_p_i` 0→2 and `cr_acc_incr_i` 0x1000→0x2000 while in WAIT → `fe_cr_*_o` unchanged until the next IDLE→SEND edge, then 2/0x2000.
- Assert `rst_i` in WAIT with 3 bytes queued → all outputs at reset values within the same cycle; no `fe_transmit_o` after release until a new push.
- Push in the same cycle as `fe_done_i` with FIFO otherwise empty → no `irq_o`; the pushed byte starts 2 cycles later.
